// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states,
// default memory depth and the alignment/size legality rule.
// Imported by data_mem_master and mem_lane_fmt.
package mem_pkg;

  localparam int DEPTH_DEF = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR       = 3'd2,
    RMW_RD   = 3'd3,
    RMW_WR   = 3'd4,
    RESP_ERR = 3'd5
  } state_e;

  // Illegal size, or a half/word that does not sit on its natural boundary.
  function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lane[0];
      SIZE_W:  bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Lane formatter: extracts and extends a byte/half/word from a memory word for
//   loads, and merges store data into the addressed lanes (little-endian).
// Purely combinational; no latency, no flow control.
// Ports: rd_word/wdata/lane/size/sign_ext in, load_data/merge_data out.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rd_word[{lane, 3'b000} +: 8];
    half_sel   = rd_word[{lane[1], 4'b0000} +: 16];
    load_data  = '0;
    merge_data = rd_word;

    case (size)
      SIZE_B: begin
        load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
        merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SIZE_W: begin
        load_data  = rd_word;
        merge_data = wdata;
      end
      default: begin
        load_data  = '0;
        merge_data = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_master.sv
// MEM-stage initiator: turns byte-addressed load/store requests into word
//   memory cycles; sub-word stores are read-modify-write.
// Latency accept->resp_valid: load/SW/error 2 cycles, SB/SH 3 cycles.
// Backpressure: req_ready only in IDLE; stall = req_valid & ~req_ready.
// Ports: clk/reset; req_* request handshake; resp_* one-cycle completion;
//   Memread/MemWrite/mem_address/mem_writeData/mem_readData to the data memory.
module data_mem_master
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [31:0]   resp_rdata,
  output logic          stall,
  output logic          Memread,
  output logic          MemWrite,
  output logic [AW-1:0] mem_address,
  output logic [31:0]   mem_writeData,
  input  logic [31:0]   mem_readData
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   merge_q, merge_d;
  logic [31:0]   wr_hold_q, wr_hold_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  logic          range_err;
  logic          req_err;
  logic [31:0]   load_data;
  logic [31:0]   merge_data;

  mem_lane_fmt u_lane_fmt (
    .rd_word    (mem_readData),
    .wdata      (wdata_q),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .sign_ext   (signed_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Request legality is judged on the live inputs at accept time, so an error
  // goes straight to RESP_ERR without ever touching the memory.
  assign range_err = ({2'b00, req_addr[AW-1:2]} >= AW'(DEPTH));
  assign req_err   = range_err | bad_shape(req_size, req_addr[1:0]);

  assign req_ready   = (state_q == IDLE);
  assign stall       = req_valid & ~req_ready;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  // addr_q only changes on accept, so the index is held across the access and after it.
  assign mem_address = {2'b00, addr_q[AW-1:2]};

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    signed_d      = signed_q;
    wdata_d       = wdata_q;
    merge_d       = merge_q;
    wr_hold_d     = wr_hold_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = '0;
    Memread       = 1'b0;
    MemWrite      = 1'b0;
    mem_writeData = wr_hold_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          if (req_err) begin
            state_d = RESP_ERR;
          end else if (!req_write) begin
            state_d = RD;
          end else if (req_size == SIZE_W) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD: begin
        Memread      = 1'b1;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data;
        state_d      = IDLE;
      end
      WR: begin
        MemWrite      = 1'b1;
        mem_writeData = wdata_q;
        wr_hold_d     = wdata_q;
        resp_valid_d  = 1'b1;
        state_d       = IDLE;
      end
      RMW_RD: begin
        Memread = 1'b1;
        merge_d = merge_data;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        MemWrite      = 1'b1;
        mem_writeData = merge_q;
        wr_hold_d     = merge_q;
        resp_valid_d  = 1'b1;
        state_d       = IDLE;
      end
      RESP_ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are decoded from state_q, so an asynchronous reset forces them low
  // immediately and an interrupted write never lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      merge_q      <= '0;
      wr_hold_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      wr_hold_q    <= wr_hold_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule
